// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset level.
module bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by the 16x oversample tick; holds one byte behind a ready flag.
//   state | meaning
//   IDLE  | waiting for a low level on the synchronised line
//   START | counting to mid start bit to reject glitches
//   DATA  | sampling payload bits at mid-bit, LSB first
//   STOP  | checking the stop bit, committing or flagging a framing error
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rxclk_en,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] MID_START = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] MID_BIT   = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_n;
    logic [SW-1:0]        sample_q, sample_n;
    logic [BW-1:0]        bit_q, bit_n;
    logic [DATA_BITS-1:0] scratch_q, scratch_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 rdy_n, frame_err_n, overrun_n;

    bit_sync #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sample_q  <= '0;
            bit_q     <= '0;
            scratch_q <= '0;
            data      <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_n;
            sample_q  <= sample_n;
            bit_q     <= bit_n;
            scratch_q <= scratch_n;
            data      <= data_n;
            rdy       <= rdy_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        sample_n    = sample_q;
        bit_n       = bit_q;
        scratch_n   = scratch_q;
        data_n      = data;
        rdy_n       = rdy;
        frame_err_n = frame_err;
        overrun_n   = overrun;

        // Clear is evaluated first so a same-cycle commit below overrides it.
        if (rdy_clr) begin
            rdy_n     = 1'b0;
            overrun_n = 1'b0;
        end

        if (rxclk_en) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_n  = START;
                        sample_n = '0;
                    end
                end
                START: begin
                    sample_n = sample_q + 1'b1;
                    if (sample_q == MID_START) begin
                        if (!rx_s) begin
                            state_n  = DATA;
                            sample_n = '0;
                            bit_n    = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                DATA: begin
                    sample_n = sample_q + 1'b1;
                    if (sample_q == MID_BIT) begin
                        scratch_n[bit_q] = rx_s;
                        sample_n         = '0;
                        if (bit_q == BIT_LAST) begin
                            state_n = STOP;
                        end else begin
                            bit_n = bit_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    sample_n = sample_q + 1'b1;
                    if (sample_q == MID_BIT) begin
                        state_n  = IDLE;
                        sample_n = '0;
                        if (rx_s) begin
                            data_n      = scratch_q;
                            rdy_n       = 1'b1;
                            frame_err_n = 1'b0;
                            if (rdy && !rdy_clr) begin
                                overrun_n = 1'b1;
                            end
                        end else begin
                            frame_err_n = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: a frame-level model predicts output changes and their timing.
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rxclk_en;
    logic       rdy_clr;
    logic [7:0] data;
    logic       rdy;
    logic       frame_err;
    logic       overrun;

    uart_rx dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rxclk_en  (rxclk_en),
        .rdy_clr   (rdy_clr),
        .data      (data),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    typedef struct {
        logic [10:0] outs;
        int          lo;
        int          hi;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ph = 0;
    logic        mon_en = 1'b0;
    logic [10:0] obs_last = '0;
    logic [10:0] pushed_last = '0;

    // Frame-level reference state: what the outputs should show.
    logic [7:0]  m_data = '0;
    logic        m_rdy = 1'b0;
    logic        m_fe = 1'b0;
    logic        m_ov = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        cyc++;
        ph = (ph + 1) % 4;
        rxclk_en = (ph == 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            rx = 1'b1;
        end
    endtask

    task automatic align();
        while (ph != 3) step();
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_emit(input int lo, input int hi);
        exp_t e;
        logic [10:0] o;
        o = {m_data, m_rdy, m_fe, m_ov};
        if (o != pushed_last) begin
            e.outs = o;
            e.lo = lo;
            e.hi = hi;
            sb.push_back(e);
            pushed_last = o;
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop, input logic clr);
        if (stop) begin
            m_ov = (m_rdy && !clr) ? 1'b1 : (clr ? 1'b0 : m_ov);
            m_rdy = 1'b1;
            m_data = b;
            m_fe = 1'b0;
        end else begin
            m_fe = 1'b1;
            if (clr) begin
                m_rdy = 1'b0;
                m_ov = 1'b0;
            end
        end
    endtask

    task automatic pulse_clr();
        step();
        rdy_clr = 1'b1;
        m_rdy = 1'b0;
        m_ov = 1'b0;
        model_emit(cyc + 1, cyc + 1);
        step();
        rdy_clr = 1'b0;
    endtask

    // One frame: start, 8 data bits LSB first, stop; 64 clk per bit. clr_at >= 0 pulses rdy_clr then.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int clr_at);
        int   k;
        int   j;
        logic lv;
        align();
        for (int n = 0; n < 640; n++) begin
            step();
            if (n == 0) begin
                k = cyc;
                model_frame(b, stop, clr_at >= 0);
                model_emit(k + 611, k + 614);
            end
            j = n / 64;
            if (j == 0) lv = 1'b0;
            else if (j == 9) lv = stop;
            else lv = b[j-1];
            rx = lv;
            rdy_clr = (n == clr_at);
        end
        step();
        rdy_clr = 1'b0;
        rx = 1'b1;
        idle(128);
    endtask

    task automatic chk_model(input string name);
        chk({name, "_data"}, data, m_data);
        chk({name, "_rdy"}, {7'd0, rdy}, {7'd0, m_rdy});
        chk({name, "_fe"}, {7'd0, frame_err}, {7'd0, m_fe});
        chk({name, "_ov"}, {7'd0, overrun}, {7'd0, m_ov});
    endtask

    // Monitor: every visible output change must match the next predicted change in its time window.
    initial begin
        logic [10:0] cur;
        exp_t        e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                cur = {data, rdy, frame_err, overrun};
                if (cur !== obs_last) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change: got %h at cycle %0d", cur, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (cur !== e.outs || cyc < e.lo || cyc > e.hi) begin
                            errors++;
                            $display("FAIL output_event: got %h at cycle %0d expected %h in cycles %0d..%0d",
                                     cur, cyc, e.outs, e.lo, e.hi);
                        end
                    end
                    obs_last = cur;
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic       stop;
        int         waited;
        rx = 1'b1;
        rxclk_en = 1'b0;
        rdy_clr = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (4) step();
        chk("reset_data", data, 8'h00);
        chk("reset_rdy", {7'd0, rdy}, 8'h00);
        chk("reset_fe", {7'd0, frame_err}, 8'h00);
        chk("reset_ov", {7'd0, overrun}, 8'h00);
        reset = 1'b0;
        mon_en = 1'b1;
        idle(64);

        send_frame(8'hA5, 1'b0, -1);
        chk("bad_stop_data", data, 8'h00);
        chk("bad_stop_rdy", {7'd0, rdy}, 8'h00);
        chk("bad_stop_fe", {7'd0, frame_err}, 8'h01);

        send_frame(8'h55, 1'b1, -1);
        chk("f55_data", data, 8'h55);
        chk("f55_rdy", {7'd0, rdy}, 8'h01);
        pulse_clr();

        align();
        for (int n = 0; n < 16; n++) begin
            step();
            rx = 1'b0;
        end
        idle(200);
        chk("glitch_rdy", {7'd0, rdy}, 8'h00);
        chk("glitch_fe", {7'd0, frame_err}, 8'h00);

        send_frame(8'h3C, 1'b1, -1);
        chk("f3c_data", data, 8'h3C);
        pulse_clr();

        send_frame(8'h12, 1'b1, -1);
        send_frame(8'h34, 1'b1, -1);
        chk("ovr_data", data, 8'h34);
        chk("ovr_rdy", {7'd0, rdy}, 8'h01);
        chk("ovr_flag", {7'd0, overrun}, 8'h01);
        pulse_clr();
        idle(4);
        chk("clr_rdy", {7'd0, rdy}, 8'h00);
        chk("clr_ov", {7'd0, overrun}, 8'h00);
        chk("clr_data", data, 8'h34);

        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h7E, 1'b1, 612);
        chk("clr_commit_data", data, 8'h7E);
        chk("clr_commit_rdy", {7'd0, rdy}, 8'h01);
        chk("clr_commit_ov", {7'd0, overrun}, 8'h00);

        b = 8'hC6;
        align();
        for (int n = 0; n < 64 * 4 + 32; n++) begin
            step();
            rx = (n < 64) ? 1'b0 : b[n/64-1];
        end
        step();
        reset = 1'b1;
        m_data = '0;
        m_rdy = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        model_emit(cyc, cyc);
        #2;
        chk("midreset_data", data, 8'h00);
        chk("midreset_rdy", {7'd0, rdy}, 8'h00);
        chk("midreset_fe", {7'd0, frame_err}, 8'h00);
        chk("midreset_ov", {7'd0, overrun}, 8'h00);
        rx = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        idle(64);

        send_frame(8'h80, 1'b1, -1);
        chk("f80_data", data, 8'h80);
        chk("f80_rdy", {7'd0, rdy}, 8'h01);
        chk("f80_fe", {7'd0, frame_err}, 8'h00);

        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) pulse_clr();
            send_frame(b, stop, -1);
            chk_model("rand");
        end

        waited = 0;
        while (sb.size() != 0 && waited < 1000) begin
            step();
            waited++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d outstanding expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
